// File: rtl/weight_bank_if.sv
// Load-stream and row-read bus for weight_bank; the master drives requests, the slave (weight_bank) responds.
interface weight_bank_if #(
  parameter int BIT_NUMBER    = 8,
  parameter int NEURAL_NUMBER = 20,
  parameter int PIXEL_AW      = 10
);
  logic                                load_start;
  logic                                load_valid;
  logic [BIT_NUMBER-1:0]               load_data;
  logic                                load_ready;
  logic                                load_done;
  logic                                rd_req;
  logic [PIXEL_AW-1:0]                 rd_pixel_addr;
  logic                                rd_valid;
  logic [BIT_NUMBER*NEURAL_NUMBER-1:0] rd_data;
  logic                                rd_oor;

  modport master (
    output load_start, load_valid, load_data, rd_req, rd_pixel_addr,
    input  load_ready, load_done, rd_valid, rd_data, rd_oor
  );

  modport slave (
    input  load_start, load_valid, load_data, rd_req, rd_pixel_addr,
    output load_ready, load_done, rd_valid, rd_data, rd_oor
  );
endinterface

// File: rtl/weight_bank.sv
// Weight SRAM: streamed full-array load, one packed row read per cycle from IDLE.
// Optional macro WEIGHT_RD_OUTREG_EN adds an output register stage (read latency 2).
module weight_bank #(
  parameter int BIT_NUMBER    = 8,
  parameter int PIXEL_NUMBER  = 784,
  parameter int NEURAL_NUMBER = 20,
  parameter int PIXEL_AW      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  weight_bank_if.slave   bus,
  output logic           busy
);
  localparam int NEU_W = (NEURAL_NUMBER > 1) ? $clog2(NEURAL_NUMBER) : 1;
  localparam int ROW_W = BIT_NUMBER * NEURAL_NUMBER;
  localparam logic [PIXEL_AW-1:0] PIX_LAST = PIXEL_AW'(PIXEL_NUMBER - 1);
  localparam logic [NEU_W-1:0]    NEU_LAST = NEU_W'(NEURAL_NUMBER - 1);
  localparam logic [PIXEL_AW:0]   PIX_NUM  = (PIXEL_AW + 1)'(PIXEL_NUMBER);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e              state_q, state_d;
  logic [PIXEL_AW-1:0] pix_cnt_q, pix_cnt_d;
  logic [NEU_W-1:0]    neu_cnt_q, neu_cnt_d;
  logic                wr_en;

  logic [BIT_NUMBER-1:0] mem [PIXEL_NUMBER][NEURAL_NUMBER];

  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    neu_cnt_d      = neu_cnt_q;
    wr_en          = 1'b0;
    bus.load_ready = 1'b0;
    bus.load_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d   = LOAD;
          pix_cnt_d = '0;
          neu_cnt_d = '0;
        end
      end
      LOAD: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          wr_en = 1'b1;
          if (neu_cnt_q == NEU_LAST) begin
            neu_cnt_d = '0;
            if (pix_cnt_q == PIX_LAST) state_d = DONE;
            else                       pix_cnt_d = pix_cnt_q + 1'b1;
          end else begin
            neu_cnt_d = neu_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        bus.load_done = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      neu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      neu_cnt_q <= neu_cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Array contents survive reset so an abandoned load keeps what it wrote.
  always_ff @(posedge clk) begin
    if (wr_en) mem[pix_cnt_q][neu_cnt_q] <= bus.load_data;
  end

  logic                rd_accept, rd_oor_hit;
  logic [PIXEL_AW-1:0] rd_idx;
  logic [ROW_W-1:0]    rd_row;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_oor_q, rd_oor_d;
  logic [ROW_W-1:0]    rd_data_q, rd_data_d;

  always_comb begin
    rd_accept  = bus.rd_req && (state_q == IDLE);
    rd_oor_hit = ({1'b0, bus.rd_pixel_addr} >= PIX_NUM);
    rd_idx     = rd_oor_hit ? '0 : bus.rd_pixel_addr;
    rd_row     = '0;
    for (int unsigned n = 0; n < NEURAL_NUMBER; n++) begin
      rd_row[n*BIT_NUMBER +: BIT_NUMBER] = mem[rd_idx][NEU_W'(n)];
    end
    rd_valid_d = rd_accept;
    rd_oor_d   = rd_accept && rd_oor_hit;
    rd_data_d  = rd_data_q;
    if (rd_accept) rd_data_d = rd_oor_hit ? '0 : rd_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_oor_q   <= rd_oor_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef WEIGHT_RD_OUTREG_EN
  logic             out_valid_q, out_valid_d;
  logic             out_oor_q, out_oor_d;
  logic [ROW_W-1:0] out_data_q, out_data_d;

  always_comb begin
    out_valid_d = rd_valid_q;
    out_oor_d   = rd_oor_q;
    out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_oor_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_oor_q   <= out_oor_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.rd_valid = out_valid_q;
  assign bus.rd_oor   = out_oor_q;
  assign bus.rd_data  = out_data_q;
`else
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_oor   = rd_oor_q;
  assign bus.rd_data  = rd_data_q;
`endif
endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank: load, readback, stalls, out-of-range, collisions, reset mid-load.
module tb_weight_bank;
  localparam int B     = 8;
  localparam int P     = 784;
  localparam int N     = 20;
  localparam int AW    = 10;
  localparam int ROW_W = B * N;
`ifdef WEIGHT_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  weight_bank_if #(.BIT_NUMBER(B), .NEURAL_NUMBER(N), .PIXEL_AW(AW)) bus ();

  weight_bank #(
    .BIT_NUMBER(B), .PIXEL_NUMBER(P), .NEURAL_NUMBER(N), .PIXEL_AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [ROW_W-1:0] pat_row(input int p);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*B +: B] = 8'((p * N + n) & 255);
    return r;
  endfunction

  function automatic logic [2:0] vexp();
    return (LAT == 1) ? 3'b001 : 3'b010;
  endfunction

  // Single read; vseq[i]/oseq[i] sampled i+1 negedges after the request cycle.
  task automatic read_one(input logic [AW-1:0] addr, output logic [2:0] vseq,
                          output logic [2:0] oseq, output logic [ROW_W-1:0] data,
                          output logic [ROW_W-1:0] dlast);
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_pixel_addr = addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rd_req = 1'b0;
      vseq[i] = bus.rd_valid;
      oseq[i] = bus.rd_oor;
      if (i == LAT - 1) data = bus.rd_data;
      dlast = bus.rd_data;
    end
  endtask

  // Streams the full pattern; stalled inserts an invalid garbage cycle before each word.
  task automatic stream_pattern(input bit stalled, output int early_done);
    early_done = 0;
    for (int p = 0; p < P; p++) begin
      for (int n = 0; n < N; n++) begin
        if (stalled) begin
          bus.load_valid = 1'b0;
          bus.load_data  = 8'hEE;
          bus.load_start = (p == 10 && n == 3);
          @(negedge clk);
          bus.load_start = 1'b0;
          if (bus.load_done) early_done++;
        end
        bus.load_valid = 1'b1;
        bus.load_data  = 8'((p * N + n) & 255);
        @(negedge clk);
        if (bus.load_done && !(p == P - 1 && n == N - 1)) early_done++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
    bus.rd_req = 1'b0; bus.rd_pixel_addr = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", bus.load_ready); end
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b expected 0", bus.load_done); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
    checks++; if (bus.rd_oor !== 1'b0) begin errors++; $display("FAIL reset_rd_oor: got %b expected 0", bus.rd_oor); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_load();
    int early;
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_in_load: got %b expected 1", bus.load_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_load: got %b expected 1", busy); end
    stream_pattern(1'b0, early);
    bus.load_valid = 1'b0;
    checks++; if (early !== 0) begin errors++; $display("FAIL full_early_done: got %0d expected 0", early); end
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL full_load_done: got %b expected 1", bus.load_done); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL full_ready_in_done: got %b expected 0", bus.load_ready); end
    @(negedge clk);
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: got %b expected 0", bus.load_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_drop: got %b expected 0", busy); end
  endtask

  task automatic test_readback();
    logic [2:0] vs, os;
    logic [ROW_W-1:0] d, dl;
    logic [ROW_W-1:0] dseq [6];
    logic [5:0] vbits;
    logic [5:0] vwant;
    read_one(10'd5, vs, os, d, dl);
    checks++; if (vs !== vexp()) begin errors++; $display("FAIL rd5_valid_seq: got %b expected %b", vs, vexp()); end
    checks++; if (os !== 3'b000) begin errors++; $display("FAIL rd5_oor: got %b expected 000", os); end
    checks++; if (d !== pat_row(5)) begin errors++; $display("FAIL rd5_data: got %h expected %h", d, pat_row(5)); end
    checks++; if (dl !== pat_row(5)) begin errors++; $display("FAIL rd5_hold: got %h expected %h", dl, pat_row(5)); end
    read_one(10'd0, vs, os, d, dl);
    checks++; if (d !== pat_row(0)) begin errors++; $display("FAIL rd0_data: got %h expected %h", d, pat_row(0)); end
    read_one(10'd783, vs, os, d, dl);
    checks++; if (d !== pat_row(783)) begin errors++; $display("FAIL rd783_data: got %h expected %h", d, pat_row(783)); end
    checks++; if (os !== 3'b000) begin errors++; $display("FAIL rd783_oor: got %b expected 000", os); end
    // back-to-back rows 5,6,7
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.rd_req = 1'b1;
      bus.rd_pixel_addr = AW'(5 + k);
      @(negedge clk);
      vbits[k] = bus.rd_valid;
      dseq[k] = bus.rd_data;
    end
    bus.rd_req = 1'b0;
    for (int k = 3; k < 6; k++) begin
      @(negedge clk);
      vbits[k] = bus.rd_valid;
      dseq[k] = bus.rd_data;
    end
    vwant = (LAT == 1) ? 6'b000111 : 6'b001110;
    checks++; if (vbits !== vwant) begin errors++; $display("FAIL b2b_valid: got %b expected %b", vbits, vwant); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dseq[k + LAT - 1] !== pat_row(5 + k)) begin
        errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, dseq[k + LAT - 1], pat_row(5 + k));
      end
    end
    checks++; if (dseq[5] !== pat_row(7)) begin errors++; $display("FAIL b2b_hold: got %h expected %h", dseq[5], pat_row(7)); end
  endtask

  task automatic test_out_of_range();
    logic [2:0] vs, os;
    logic [ROW_W-1:0] d, dl;
    logic [AW-1:0] addrs [3];
    addrs[0] = 10'd800; addrs[1] = 10'd784; addrs[2] = 10'd1023;
    for (int i = 0; i < 3; i++) begin
      read_one(10'd1, vs, os, d, dl);
      read_one(addrs[i], vs, os, d, dl);
      checks++; if (vs !== vexp()) begin errors++; $display("FAIL oor%0d_valid: got %b expected %b", addrs[i], vs, vexp()); end
      checks++; if (os !== vexp()) begin errors++; $display("FAIL oor%0d_flag: got %b expected %b", addrs[i], os, vexp()); end
      checks++; if (d !== '0) begin errors++; $display("FAIL oor%0d_data: got %h expected 0", addrs[i], d); end
    end
  endtask

  task automatic test_collisions();
    logic [2:0] vs;
    logic [ROW_W-1:0] d;
    logic b;
    int hits;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_pixel_addr = 10'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.load_start = 1'b0;
      bus.rd_req = 1'b0;
      vs[i] = bus.rd_valid;
      if (i == LAT - 1) d = bus.rd_data;
      if (i == 0) b = busy;
    end
    checks++; if (vs !== vexp()) begin errors++; $display("FAIL coll_valid_seq: got %b expected %b", vs, vexp()); end
    checks++; if (d !== pat_row(5)) begin errors++; $display("FAIL coll_data: got %h expected %h", d, pat_row(5)); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", b); end
    hits = 0;
    bus.rd_req = 1'b1;
    bus.rd_pixel_addr = 10'd6;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) bus.rd_req = 1'b0;
      if (bus.rd_valid) hits++;
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL load_rd_dropped: got %0d valids expected 0", hits); end
    checks++; if (bus.rd_data !== pat_row(5)) begin errors++; $display("FAIL load_rd_hold: got %h expected %h", bus.rd_data, pat_row(5)); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    logic [2:0] vs, os;
    logic [ROW_W-1:0] d, dl, e;
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data = 8'(8'h80 + k);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", bus.load_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid: got %b expected 0", bus.rd_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int n = 0; n < N; n++) begin
      bus.load_valid = 1'b1;
      bus.load_data = 8'(8'h40 + n);
      @(negedge clk);
    end
    bus.load_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < N; n++) begin
        case (p)
          0:       e[n*B +: B] = 8'(8'h40 + n);
          1:       e[n*B +: B] = 8'(8'h80 + 20 + n);
          2:       e[n*B +: B] = (n < 10) ? 8'(8'h80 + 40 + n) : 8'(40 + n);
          default: e[n*B +: B] = 8'(60 + n);
        endcase
      end
      read_one(AW'(p), vs, os, d, dl);
      checks++; if (d !== e) begin errors++; $display("FAIL midrst_row%0d: got %h expected %h", p, d, e); end
    end
  endtask

  task automatic test_stalled_load();
    int early;
    logic [2:0] vs, os;
    logic [ROW_W-1:0] d, dl;
    int rows [5];
    rows[0] = 0; rows[1] = 1; rows[2] = 2; rows[3] = 5; rows[4] = 783;
    @(negedge clk);
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    stream_pattern(1'b1, early);
    bus.load_valid = 1'b0;
    checks++; if (early !== 0) begin errors++; $display("FAIL stall_early_done: got %0d expected 0", early); end
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL stall_load_done: got %b expected 1", bus.load_done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_drop: got %b expected 0", busy); end
    for (int i = 0; i < 5; i++) begin
      read_one(AW'(rows[i]), vs, os, d, dl);
      checks++;
      if (d !== pat_row(rows[i])) begin
        errors++; $display("FAIL stall_row%0d: got %h expected %h", rows[i], d, pat_row(rows[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_readback();
    test_out_of_range();
    test_collisions();
    test_reset_mid_load();
    test_stalled_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
